sdf_dif_stage: RTL and testbench



---
 rtl/ntt_pkg.sv | 24 ++
 rtl/mod_addsub_comb.sv | 28 ++
 rtl/sdf_dif_stage.sv | 134 +++++++++++++
 tb/tb_sdf_dif_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the streaming NTT datapath: SDF stage state encoding
// and the constant log2 helper used to size per-stage counters.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_COMPUTE  = 2'd1,
        ST_FILL_OUT = 2'd2,
        ST_DRAIN    = 2'd3
    } sdf_state_t;

    // Ceiling log2, evaluated at elaboration time for parameter derivation.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_addsub_comb.sv
// Combinational modular adder/subtractor shared by every SDF butterfly stage.
// Operands are assumed already reduced below q.
module mod_addsub_comb #(
    parameter int LOGQ = 32
) (
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] b,
    input  logic [LOGQ-1:0] q,
    output logic [LOGQ-1:0] sum_mod,
    output logic [LOGQ-1:0] diff_mod
);

    logic [LOGQ:0] sum_raw;
    logic [LOGQ:0] sum_red;
    logic [LOGQ:0] diff_raw;
    logic [LOGQ:0] diff_fix;

    always_comb begin
        // One extra bit keeps the carry of a+b and the sign of a-b.
        sum_raw  = {1'b0, a} + {1'b0, b};
        sum_red  = sum_raw - {1'b0, q};
        sum_mod  = (sum_raw >= {1'b0, q}) ? sum_red[LOGQ-1:0] : sum_raw[LOGQ-1:0];
        diff_raw = {1'b0, a} - {1'b0, b};
        diff_fix = diff_raw + {1'b0, q};
        diff_mod = diff_raw[LOGQ] ? diff_fix[LOGQ-1:0] : diff_raw[LOGQ-1:0];
    end

endmodule

// File: rtl/sdf_dif_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage: buffers half a block,
// emits sums while storing differences, then replays differences next block.
module sdf_dif_stage
    import ntt_pkg::*;
#(
    parameter int LOGQ = 32,
    parameter int D    = 8,
    parameter int LOGD = clog2(D)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LOGQ-1:0] q,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] in_data,
    output logic            out_valid,
    output logic [LOGQ-1:0] out_data
);

    sdf_state_t      state_q, state_d;
    logic [LOGD-1:0] cnt_q, cnt_d;
    logic [LOGQ-1:0] dl_q [D];
    logic            out_valid_q, out_valid_d;
    logic [LOGQ-1:0] out_data_q, out_data_d;

    logic            step;
    logic [LOGQ-1:0] push_val;
    logic [LOGQ-1:0] head;
    logic [LOGQ-1:0] sum_mod;
    logic [LOGQ-1:0] diff_mod;
    logic            accept;
    logic            cnt_last;

    assign head     = dl_q[D-1];
    assign cnt_last = (cnt_q == LOGD'(D - 1));

    mod_addsub_comb #(.LOGQ(LOGQ)) u_addsub (
        .a        (head),
        .b        (in_data),
        .q        (q),
        .sum_mod  (sum_mod),
        .diff_mod (diff_mod)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step        = 1'b0;
        push_val    = in_data;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        in_ready    = (state_q != ST_DRAIN);
        accept      = in_valid && in_ready;

        // cnt wraps to zero naturally at the end of each half-block since D is a power of two.
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    step  = 1'b1;
                    cnt_d = cnt_q + LOGD'(1);
                    if (cnt_last) begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (accept) begin
                    step        = 1'b1;
                    push_val    = diff_mod;
                    out_valid_d = 1'b1;
                    out_data_d  = sum_mod;
                    cnt_d       = cnt_q + LOGD'(1);
                    if (cnt_last) begin
                        state_d = ST_FILL_OUT;
                    end
                end
            end
            ST_FILL_OUT: begin
                if (accept) begin
                    step        = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = head;
                    cnt_d       = cnt_q + LOGD'(1);
                    if (cnt_last) begin
                        state_d = ST_COMPUTE;
                    end
                end else if (cnt_q == '0) begin
                    // No next frame ready: flush the stored differences on our own.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                step        = 1'b1;
                push_val    = '0;
                out_valid_d = 1'b1;
                out_data_d  = head;
                cnt_d       = cnt_q + LOGD'(1);
                if (cnt_last) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < D; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (step) begin
                dl_q[0] <= push_val;
                for (int i = 1; i < D; i++) begin
                    dl_q[i] <= dl_q[i-1];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sdf_dif_stage.sv
// Scoreboard bench for sdf_dif_stage: a frame-level butterfly model queues the
// expected output stream, a negedge monitor compares every valid output.
module tb_sdf_dif_stage;

    localparam int LOGQ = 32;
    localparam int D    = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [LOGQ-1:0] q = 32'd17;
    logic            in_valid = 1'b0;
    logic [LOGQ-1:0] in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [LOGQ-1:0] out_data;

    sdf_dif_stage #(.LOGQ(LOGQ), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stalls = 0;
    int last_acc = 0;
    logic [LOGQ-1:0] sb [$];
    int out_cyc [$];
    logic [LOGQ-1:0] fr [2*D];
    logic [LOGQ-1:0] exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every valid output consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                exp_v = sb.pop_front();
                total++;
                if (out_data !== exp_v) begin
                    bad++;
                    $display("FAIL out_data: got %0d expected %0d", out_data, exp_v);
                end else begin
                    $display("out %0d cycle %0d", out_data, cyc);
                end
            end
        end
    end

    task automatic put(input logic [LOGQ-1:0] v);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready) begin
            stalls++;
            n++;
            if (n > 100) begin
                $display("FAIL in_ready_timeout: got 0 expected 1");
                bad++;
                total++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "in_ready stuck low");
            end
            @(negedge clk);
        end
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Reference: sums of the pair (x[i], x[i+D]) then their differences, mod q.
    task automatic push_model();
        longint unsigned a, b, m;
        m = {32'd0, q};
        for (int i = 0; i < D; i++) begin
            a = {32'd0, fr[i]};
            b = {32'd0, fr[i+D]};
            sb.push_back(LOGQ'((a + b) % m));
        end
        for (int i = 0; i < D; i++) begin
            a = {32'd0, fr[i]};
            b = {32'd0, fr[i+D]};
            sb.push_back(LOGQ'((a + m - b) % m));
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 2*D; i++) fr[i] = $urandom_range(q - 1, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, low;
        logic [LOGQ-1:0] k1 [2*D];
        logic [LOGQ-1:0] k2 [2*D];
        k1 = '{32'd4, 32'd6, 32'd8, 32'd10, 32'd13, 32'd13, 32'd13, 32'd13};
        k2 = '{32'd15, 32'd13, 32'd15, 32'd13, 32'd0, 32'd0, 32'd0, 32'd0};

        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // Basic butterfly with a drain
        for (int i = 0; i < 2*D; i++) sb.push_back(k1[i]);
        base = out_cyc.size();
        for (int i = 0; i < 2*D; i++) begin
            put(LOGQ'(i));
            if (i == 0) t0 = last_acc;
        end
        low = 0;
        repeat (3*D) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (!in_ready) low++;
        end
        check("drain_ready_low_cycles", low, D);
        check("first_sum_latency", out_cyc.size() > base ? out_cyc[base] - t0 : -1, D + 1);
        check("basic_queue_empty", sb.size(), 0);

        // Wrap-around of both sum and difference
        for (int i = 0; i < 2*D; i++) sb.push_back(k2[i]);
        for (int i = 0; i < 2*D; i++) put((i % 2 == 0) ? 32'd16 : 32'd15);
        idle(3*D);
        check("wrap_queue_empty", sb.size(), 0);

        // Back-to-back frames: diffs interleave with the next fill
        base = out_cyc.size();
        stalls = 0;
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            push_model();
            for (int i = 0; i < 2*D; i++) begin
                put(fr[i]);
                if (f == 0 && i == 0) t0 = last_acc;
            end
        end
        idle(3*D);
        check("b2b_no_ready_drop", stalls, 0);
        for (int i = 0; i < D; i++) begin
            check("b2b_diff_cycle",
                  out_cyc.size() > base + D + i ? out_cyc[base + D + i] - t0 : -1,
                  2*D + 1 + i);
        end
        check("b2b_queue_empty", sb.size(), 0);

        // Stall of 3 cycles in the middle of COMPUTE
        base = out_cyc.size();
        rand_frame();
        push_model();
        for (int i = 0; i < 2*D; i++) begin
            if (i == D + 1) idle(3);
            put(fr[i]);
        end
        idle(3*D);
        check("stall_out_gap",
              out_cyc.size() > base + 1 ? out_cyc[base + 1] - out_cyc[base] : -1, 4);
        check("stall_queue_empty", sb.size(), 0);

        // Reset during COMPUTE discards the partial frame
        rand_frame();
        push_model();
        for (int i = 0; i < D + 2; i++) put(fr[i]);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check("rst_out_valid_immediate", out_valid, 0);
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b0;
        idle(2*D);
        check("rst_in_ready", in_ready, 1);
        rand_frame();
        push_model();
        for (int i = 0; i < 2*D; i++) put(fr[i]);
        idle(3*D);
        check("post_reset_queue_empty", sb.size(), 0);

        // Random frames with the production-size modulus
        q = 32'hFFFF_FFFB;
        for (int f = 0; f < 1000; f++) begin
            rand_frame();
            push_model();
            for (int i = 0; i < 2*D; i++) begin
                if ($urandom_range(7, 0) == 0) idle($urandom_range(2, 1));
                put(fr[i]);
            end
            if ($urandom_range(3, 0) == 0) idle($urandom_range(D + 2, 1));
        end
        idle(4*D);
        check("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
